sp_ram_fifo_ctrl: RTL and testbench

FIFO controller that turns the 128 x 8 single-port RAM into a first-in/first-out buffer. It sits directly upstream of the RAM and drives its write-enable, read-enable, address and write-data ports. It consumes the RAM's registered read data. Because the RAM has one port, at most one RAM access happens per cycle; the block arbitrates push against pop round-robin.

---
 rtl/sp_ram_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_sp_ram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller that drives a single-port RAM, with round-robin push/pop arbitration.
// Optional sticky overflow/underflow flag on err_o when SP_FIFO_ERR_FLAGS_EN is defined.
module sp_ram_fifo_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  input  logic              pop_i,
  output logic              pop_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
`ifdef SP_FIFO_ERR_FLAGS_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              prio_r;
  logic              rd_valid_r;

  logic full_s;
  logic empty_s;
  logic push_elig_s;
  logic pop_elig_s;
  logic push_gnt_s;
  logic pop_gnt_s;

  assign full_s      = (count_r == DEPTH_C);
  assign empty_s     = (count_r == '0);
  assign push_elig_s = push_i && !full_s;
  assign pop_elig_s  = pop_i && !empty_s;

  // prio_r breaks the tie only when both sides are eligible, so at most one grant fires.
  assign push_ready_o = !full_s && (!pop_elig_s || (prio_r == 1'b0));
  assign pop_ready_o  = !empty_s && (!push_elig_s || (prio_r == 1'b1));
  assign push_gnt_s   = push_i && push_ready_o;
  assign pop_gnt_s    = pop_i && pop_ready_o;

  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign count_o    = count_r;
  assign rd_valid_o = rd_valid_r;
  assign rd_data_o  = ram_rd_data_i;

  // RAM port steering for the single access granted this cycle.
  always_comb begin
    ram_wr_en_o   = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_addr_o    = rd_ptr_r;
    ram_wr_data_o = push_data_i;
    if (push_gnt_s) begin
      ram_wr_en_o = 1'b1;
      ram_addr_o  = wr_ptr_r;
    end else if (pop_gnt_s) begin
      ram_rd_en_o = 1'b1;
    end else begin
      ram_addr_o  = rd_ptr_r;
    end
  end

  // Pointer, occupancy, arbitration priority and read-valid state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      prio_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= pop_gnt_s;
      if (push_gnt_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + ADDR_W'(1);
        count_r  <= count_r + (ADDR_W+1)'(1);
        prio_r   <= 1'b1;
      end else if (pop_gnt_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + ADDR_W'(1);
        count_r  <= count_r - (ADDR_W+1)'(1);
        prio_r   <= 1'b0;
      end else begin
        prio_r   <= prio_r;
      end
    end
  end

`ifdef SP_FIFO_ERR_FLAGS_EN
  logic err_r;
  assign err_o = err_r;

  // Sticky flag: any request against a full or empty FIFO latches until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r <= 1'b0;
    end else if ((push_i && full_s) || (pop_i && empty_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Scoreboard bench for sp_ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_sp_ram_fifo_ctrl;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              push_i = 1'b0;
  logic [DATA_W-1:0] push_data_i = 8'h00;
  logic              push_ready_o;
  logic              pop_i = 1'b0;
  logic              pop_ready_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              ram_wr_en_o;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wr_data_o;
  logic [DATA_W-1:0] ram_rd_data = 8'h00;
`ifdef SP_FIFO_ERR_FLAGS_EN
  logic              err_o;
`endif

  sp_ram_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .push_i(push_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .pop_i(pop_i), .pop_ready_o(pop_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_rd_en_o(ram_rd_en_o),
    .ram_addr_o(ram_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_data_i(ram_rd_data)
`ifdef SP_FIFO_ERR_FLAGS_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // 128 x 8 single-port RAM with registered read data
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_wr_en_o) mem[ram_addr_o] <= ram_wr_data_o;
    if (ram_rd_en_o) ram_rd_data <= mem[ram_addr_o];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, addresses as running indices modulo DEPTH
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  int  wr_idx = 0;
  int  rd_idx = 0;
  bit  prio_m = 1'b0;
  bit  rv_exp = 1'b0;
  bit  err_exp = 1'b0;

  always @(negedge clk_i) begin
    bit pe, oe, exp_pr, exp_or, gp, go;
    int sz;
    if (!rst_n_i) begin
      mq.delete(); exp_q.delete();
      wr_idx = 0; rd_idx = 0; prio_m = 1'b0; rv_exp = 1'b0; err_exp = 1'b0;
    end else begin
      sz = mq.size();
      chk("count", int'(count_o), sz);
      chk("full", int'(full_o), int'(sz == DEPTH));
      chk("empty", int'(empty_o), int'(sz == 0));
      chk("rd_valid", int'(rd_valid_o), int'(rv_exp));
`ifdef SP_FIFO_ERR_FLAGS_EN
      chk("err", int'(err_o), int'(err_exp));
      if ((push_i && sz == DEPTH) || (pop_i && sz == 0)) err_exp = 1'b1;
`endif
      pe = push_i && (sz < DEPTH);
      oe = pop_i && (sz > 0);
      exp_pr = (sz < DEPTH) && (!oe || !prio_m);
      exp_or = (sz > 0) && (!pe || prio_m);
      chk("push_ready", int'(push_ready_o), int'(exp_pr));
      chk("pop_ready", int'(pop_ready_o), int'(exp_or));
      gp = push_i && exp_pr;
      go = pop_i && exp_or;
      if (gp) begin
        chk("wr_en", int'(ram_wr_en_o), 1);
        chk("rd_en_on_push", int'(ram_rd_en_o), 0);
        chk("wr_addr", int'(ram_addr_o), wr_idx);
        chk("wr_data", int'(ram_wr_data_o), int'(push_data_i));
        mq.push_back(push_data_i);
        wr_idx = (wr_idx + 1) % DEPTH;
        prio_m = 1'b1;
      end else if (go) begin
        chk("rd_en", int'(ram_rd_en_o), 1);
        chk("wr_en_on_pop", int'(ram_wr_en_o), 0);
        chk("rd_addr", int'(ram_addr_o), rd_idx);
        exp_q.push_back(mq.pop_front());
        rd_idx = (rd_idx + 1) % DEPTH;
        prio_m = 1'b0;
      end else begin
        chk("idle_wr_en", int'(ram_wr_en_o), 0);
        chk("idle_rd_en", int'(ram_rd_en_o), 0);
        chk("idle_addr", int'(ram_addr_o), rd_idx);
      end
      rv_exp = go;
    end
  end

  // Monitor: every presented read word is matched against the scoreboard head
  always @(negedge clk_i) begin
    if (rst_n_i && rd_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        chk("rd_data", int'(rd_data_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_n(input int base, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      push_i = 1'b1;
      push_data_i = DATA_W'(base + i);
      g = 0;
      @(negedge clk_i);
      while (!push_ready_o && g < 300) begin
        @(negedge clk_i);
        g++;
      end
      if (g >= 300) chk("push_timeout", 1, 0);
    end
    @(posedge clk_i); #1;
    push_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    @(posedge clk_i); #1;
    pop_i = 1'b1;
    do begin
      @(posedge clk_i);
      g++;
    end while (mq.size() > 0 && g < 2000);
    if (g >= 2000) chk("drain_timeout", 1, 0);
    #1 pop_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic hold_req(input bit p, input bit q, input int cycles);
    bit acc = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < cycles; i++) begin
      if (acc) push_data_i = DATA_W'($urandom);
      push_i = p;
      pop_i = q;
      @(negedge clk_i);
      acc = push_ready_o;
      @(posedge clk_i); #1;
    end
    push_i = 1'b0;
    pop_i = 1'b0;
  endtask

  task automatic rand_run(input int cycles, input int push_pct, input int pop_pct);
    bit acc = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (!push_i || acc) begin
        push_i = ($urandom_range(99) < push_pct);
        push_data_i = DATA_W'($urandom);
      end
      pop_i = ($urandom_range(99) < pop_pct);
      @(negedge clk_i);
      acc = push_ready_o;
    end
    @(posedge clk_i); #1;
    push_i = 1'b0;
    pop_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);

    push_n(8'h45, 1);
    push_n(8'h22, 1);
    drain();

    push_n(0, DEPTH);
    hold_req(1'b1, 1'b0, 4);
    drain();
    hold_req(1'b0, 1'b1, 4);

    push_n(0, 100);
    drain();
    push_n(8'h80, 60);
    drain();

    push_n(8'h10, 5);
    hold_req(1'b1, 1'b1, 12);
    drain();

    rand_run(3000, 85, 40);
    rand_run(3000, 40, 85);
    rand_run(2000, 60, 60);
    drain();

    push_n(8'hA0, 3);
    @(posedge clk_i); #1;
    pop_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    pop_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("rst_rd_valid", int'(rd_valid_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_pop_ready", int'(pop_ready_o), 0);
`ifdef SP_FIFO_ERR_FLAGS_EN
    chk("rst_err", int'(err_o), 0);
`endif
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    push_n(8'h5A, 2);
    drain();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
